// File: rtl/platform_contact_scanner_pkg.sv
// Shared types for the platform contact scanner: FSM encoding, descriptor
// layout and the default stage level used by the level loader.
package platform_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  localparam int LVL_CW       = 10;
  localparam int LVL_NUM_PLAT = 6;
  localparam int LVL_FLOOR_Y  = 464;

  // Field order matches the register file entries: en, y, x_lo, x_hi.
  typedef struct packed {
    logic              en;
    logic [LVL_CW-1:0] y;
    logic [LVL_CW-1:0] x_lo;
    logic [LVL_CW-1:0] x_hi;
  } plat_desc_t;

  function automatic plat_desc_t mk_desc(input int y, input int lo, input int hi);
    mk_desc.en   = 1'b1;
    mk_desc.y    = LVL_CW'(y);
    mk_desc.x_lo = LVL_CW'(lo);
    mk_desc.x_hi = LVL_CW'(hi);
  endfunction

  localparam plat_desc_t [LVL_NUM_PLAT-1:0] LVL_PLAT = {
    mk_desc(176, 384, 576), mk_desc(176,  64, 256),
    mk_desc(272, 320, 480), mk_desc(272, 160, 320),
    mk_desc(368, 480, 640), mk_desc(368,   0, 160)
  };

endpackage

// File: rtl/platform_contact_scanner_if.sv
// Config/request/result bundle between motion controller, level loader and scanner.
interface platform_contact_scanner_if #(
  parameter int COORD_W = 10,
  parameter int IDX_W   = 3
);
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_idx;
  logic               cfg_en;
  logic [COORD_W-1:0] cfg_y;
  logic [COORD_W-1:0] cfg_x_lo;
  logic [COORD_W-1:0] cfg_x_hi;
  logic               start;
  logic [COORD_W-1:0] jojo_x;
  logic [COORD_W-1:0] jojo_y;
  logic               jumping_up;
  logic               busy;
  logic               done;
  logic               grounded;
  logic               hit_floor;
  logic [IDX_W-1:0]   plat_idx;
  logic [COORD_W-1:0] snap_y;

  modport master (
    output cfg_we, cfg_idx, cfg_en, cfg_y, cfg_x_lo, cfg_x_hi,
    output start, jojo_x, jojo_y, jumping_up,
    input  busy, done, grounded, hit_floor, plat_idx, snap_y
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_en, cfg_y, cfg_x_lo, cfg_x_hi,
    input  start, jojo_x, jojo_y, jumping_up,
    output busy, done, grounded, hit_floor, plat_idx, snap_y
  );
endinterface

// File: rtl/platform_contact_scanner_table.sv
// Platform descriptor register file: one sync write port, one async read port.
module platform_table #(
  parameter int COORD_W  = 10,
  parameter int NUM_PLAT = 8,
  parameter int IDX_W    = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               we,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic               wr_en,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [COORD_W-1:0] wr_x_lo,
  input  logic [COORD_W-1:0] wr_x_hi,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_en,
  output logic [COORD_W-1:0] rd_y,
  output logic [COORD_W-1:0] rd_x_lo,
  output logic [COORD_W-1:0] rd_x_hi
);
  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x_lo;
    logic [COORD_W-1:0] x_hi;
  } desc_t;

  desc_t tab_q [NUM_PLAT];

  for (genvar g = 0; g < NUM_PLAT; g++) begin : g_ent
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        tab_q[g] <= '0;
      else if (we && wr_idx == IDX_W'(g))
        tab_q[g] <= '{en: wr_en, y: wr_y, x_lo: wr_x_lo, x_hi: wr_x_hi};
    end
  end

  assign rd_en   = tab_q[rd_idx].en;
  assign rd_y    = tab_q[rd_idx].y;
  assign rd_x_lo = tab_q[rd_idx].x_lo;
  assign rd_x_hi = tab_q[rd_idx].x_hi;
endmodule

// File: rtl/platform_contact_scanner.sv
// Per-frame ground test: walks the platform table once per start and
// reports the lowest-index supporting platform, the floor, or airborne.
module platform_contact_scanner
  import platform_pkg::*;
#(
  parameter int COORD_W  = 10,
  parameter int NUM_PLAT = 8,
  parameter int IDX_W    = 3,
  parameter int SPRITE_H = 64,
  parameter int FLOOR_Y  = 464,
  parameter int SNAP_TOL = 0
) (
  input logic                  clk,
  input logic                  reset_n,
  platform_contact_scanner_if.slave bus
);
  localparam int                 FEET_W     = COORD_W + 1;
  localparam logic [FEET_W-1:0]  FLOOR_FEET = FEET_W'(FLOOR_Y);
  localparam logic [COORD_W-1:0] FLOOR_SNAP = COORD_W'(FLOOR_Y - SPRITE_H);
  localparam logic [COORD_W-1:0] TOL        = COORD_W'(SNAP_TOL);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_PLAT - 1);

  scan_state_e        state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [FEET_W-1:0]  feet_q, feet_d;
  logic               jump_q, jump_d;
  logic               mvld_q, mvld_d;
  logic [IDX_W-1:0]   midx_q, midx_d;
  logic [COORD_W-1:0] my_q, my_d;
  logic               done_q, done_d, grnd_q, grnd_d, flr_q, flr_d;
  logic [IDX_W-1:0]   pidx_q, pidx_d;
  logic [COORD_W-1:0] snap_q, snap_d;

  logic               rd_en, hit;
  logic [COORD_W-1:0] rd_y, rd_x_lo, rd_x_hi, y_lo;

  platform_table #(.COORD_W(COORD_W), .NUM_PLAT(NUM_PLAT), .IDX_W(IDX_W)) u_tab (
    .clk(clk), .reset_n(reset_n),
    .we(bus.cfg_we), .wr_idx(bus.cfg_idx), .wr_en(bus.cfg_en),
    .wr_y(bus.cfg_y), .wr_x_lo(bus.cfg_x_lo), .wr_x_hi(bus.cfg_x_hi),
    .rd_idx(cnt_q), .rd_en(rd_en), .rd_y(rd_y), .rd_x_lo(rd_x_lo), .rd_x_hi(rd_x_hi)
  );

  // Landing window [y - TOL, y], lower bound clamped at 0.
  assign y_lo = (rd_y >= TOL) ? rd_y - TOL : '0;
  assign hit  = rd_en && (x_q >= rd_x_lo) && (x_q < rd_x_hi) &&
                (feet_q >= {1'b0, y_lo}) && (feet_q <= {1'b0, rd_y});

  always_comb begin
    state_d = state_q; cnt_d = cnt_q;
    x_d = x_q; y_d = y_q; feet_d = feet_q; jump_d = jump_q;
    mvld_d = mvld_q; midx_d = midx_q; my_d = my_q;
    done_d = 1'b0; grnd_d = grnd_q; flr_d = flr_q; pidx_d = pidx_q; snap_d = snap_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) begin
        x_d     = bus.jojo_x;
        y_d     = bus.jojo_y;
        jump_d  = bus.jumping_up;
        feet_d  = {1'b0, bus.jojo_y} + FEET_W'(SPRITE_H);
        mvld_d  = 1'b0;
        cnt_d   = '0;
        state_d = bus.jumping_up ? ST_DONE : ST_SCAN;
      end
      ST_SCAN: begin
        if (hit && !mvld_q) begin
          mvld_d = 1'b1;
          midx_d = cnt_q;
          my_d   = rd_y;
        end
        if (cnt_q == LAST_IDX) state_d = ST_DONE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
        grnd_d = 1'b0; flr_d = 1'b0; pidx_d = '0; snap_d = y_q;
        if (jump_q) begin
          grnd_d = 1'b0;
        end else if (mvld_q) begin
          grnd_d = 1'b1; pidx_d = midx_q; snap_d = my_q - COORD_W'(SPRITE_H);
        end else if (feet_q >= FLOOR_FEET) begin
          grnd_d = 1'b1; flr_d = 1'b1; snap_d = FLOOR_SNAP;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE; cnt_q <= '0;
      x_q <= '0; y_q <= '0; feet_q <= '0; jump_q <= 1'b0;
      mvld_q <= 1'b0; midx_q <= '0; my_q <= '0;
      done_q <= 1'b0; grnd_q <= 1'b1; flr_q <= 1'b1; pidx_q <= '0; snap_q <= FLOOR_SNAP;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d;
      x_q <= x_d; y_q <= y_d; feet_q <= feet_d; jump_q <= jump_d;
      mvld_q <= mvld_d; midx_q <= midx_d; my_q <= my_d;
      done_q <= done_d; grnd_q <= grnd_d; flr_q <= flr_d; pidx_q <= pidx_d; snap_q <= snap_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.grounded  = grnd_q;
  assign bus.hit_floor = flr_q;
  assign bus.plat_idx  = pidx_q;
  assign bus.snap_y    = snap_q;
endmodule

// File: tb/tb_platform_contact_scanner.sv
// Directed scoreboard bench: stimulus pushes expected results, a negedge
// monitor pops one per done pulse and also checks the done cycle.
module tb_platform_contact_scanner;
  localparam int CW = 10, NP = 8, IW = 3;

  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  platform_contact_scanner_if #(.COORD_W(CW), .IDX_W(IW)) bus();

  platform_contact_scanner #(
    .COORD_W(CW), .NUM_PLAT(NP), .IDX_W(IW),
    .SPRITE_H(64), .FLOOR_Y(464), .SNAP_TOL(4)
  ) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    string name;
    int    g, hf, idx, snap, cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0, bad = 0;

  always @(negedge clk) begin
    if (bus.done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: done at cycle %0d, required no done", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(bus.grounded) != mon_e.g || int'(bus.hit_floor) != mon_e.hf ||
            int'(bus.plat_idx) != mon_e.idx || int'(bus.snap_y) != mon_e.snap || cyc != mon_e.cyc) begin
          bad++;
          $display("FAIL %s: got cyc=%0d g=%0d hf=%0d idx=%0d snap=%0d, required cyc=%0d g=%0d hf=%0d idx=%0d snap=%0d",
                   mon_e.name, cyc, bus.grounded, bus.hit_floor, bus.plat_idx, bus.snap_y,
                   mon_e.cyc, mon_e.g, mon_e.hf, mon_e.idx, mon_e.snap);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic wr(input int idx, input int en, input int y, input int lo, input int hi);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_idx = IW'(idx); bus.cfg_en = en[0];
    bus.cfg_y = CW'(y); bus.cfg_x_lo = CW'(lo); bus.cfg_x_hi = CW'(hi);
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Issue one start and push its expected result; c0 is the sampling edge.
  task automatic scan(input string name, input int x, input int y, input int jmp,
                      input int g, input int hf, input int idx, input int snap);
    int c0;
    @(negedge clk);
    bus.jojo_x = CW'(x); bus.jojo_y = CW'(y); bus.jumping_up = jmp[0]; bus.start = 1'b1;
    c0 = cyc + 1;
    exp_q.push_back('{name, g, hf, idx, snap, c0 + (jmp != 0 ? 1 : NP + 1)});
    @(negedge clk);
    bus.start = 1'b0; bus.jumping_up = 1'b0;
    drain();
  endtask

  initial begin
    int c0;
    bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_en = 0; bus.cfg_y = '0;
    bus.cfg_x_lo = '0; bus.cfg_x_hi = '0; bus.start = 0;
    bus.jojo_x = '0; bus.jojo_y = '0; bus.jumping_up = 0;

    repeat (2) @(negedge clk);
    chk("rst_grounded", int'(bus.grounded), 1);
    chk("rst_hit_floor", int'(bus.hit_floor), 1);
    chk("rst_plat_idx", int'(bus.plat_idx), 0);
    chk("rst_snap_y", int'(bus.snap_y), 400);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    reset_n = 1'b1;

    scan("empty_table", 100, 100, 0, 0, 0, 0, 100);

    wr(2, 1, 215, 64, 550);
    scan("plat_hit", 100, 151, 0, 1, 0, 2, 151);
    chk("busy_idle_after", int'(bus.busy), 0);
    scan("span_hi_excl", 550, 151, 0, 0, 0, 0, 151);
    scan("span_lo_incl", 64, 151, 0, 1, 0, 2, 151);
    scan("span_below_lo", 63, 151, 0, 0, 0, 0, 151);

    wr(0, 1, 215, 600, 600);
    scan("empty_span", 600, 151, 0, 0, 0, 0, 151);

    wr(1, 1, 300, 0, 200);
    wr(5, 1, 300, 100, 400);
    scan("overlap_prio", 150, 236, 0, 1, 0, 1, 236);
    scan("jump_on_plat", 150, 236, 1, 0, 0, 0, 236);

    scan("floor_exact", 700, 400, 0, 1, 1, 0, 400);
    scan("floor_below", 700, 420, 0, 1, 1, 0, 400);
    scan("floor_above", 700, 399, 0, 0, 0, 0, 399);
    scan("jump_on_floor", 700, 400, 1, 0, 0, 0, 400);

    scan("tol_inside", 100, 148, 0, 1, 0, 2, 151);
    scan("tol_outside", 100, 146, 0, 0, 0, 0, 146);
    scan("below_surface", 100, 152, 0, 0, 0, 0, 152);
    scan("tol_low_edge", 100, 232, 0, 1, 0, 1, 236);

    // start held high: only the first IDLE edge after done starts scan two
    @(negedge clk);
    bus.jojo_x = CW'(100); bus.jojo_y = CW'(151); bus.start = 1'b1;
    c0 = cyc + 1;
    exp_q.push_back('{"period_first", 1, 0, 2, 151, c0 + NP + 1});
    exp_q.push_back('{"period_second", 1, 0, 2, 151, c0 + 2 * NP + 3});
    while (cyc != c0 + 2) @(negedge clk);
    chk("busy_in_scan", int'(bus.busy), 1);
    bus.jojo_x = CW'(700); bus.jojo_y = CW'(400);
    while (cyc != c0 + NP + 1) @(negedge clk);
    bus.jojo_x = CW'(100); bus.jojo_y = CW'(151);
    while (cyc != c0 + NP + 2) @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (12) @(negedge clk);

    wr(3, 1, 260, 700, 800);
    @(negedge clk);
    bus.jojo_x = CW'(750); bus.jojo_y = CW'(196); bus.start = 1'b1;
    c0 = cyc + 1;
    exp_q.push_back('{"race_old_value", 1, 0, 3, 196, c0 + NP + 1});
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc != c0 + 3) @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_idx = IW'(3); bus.cfg_en = 1'b0;
    bus.cfg_y = CW'(260); bus.cfg_x_lo = CW'(700); bus.cfg_x_hi = CW'(800);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    drain();
    scan("race_new_value", 750, 196, 0, 0, 0, 0, 196);

    // reset mid-scan: no done, reset values, table cleared
    @(negedge clk);
    bus.jojo_x = CW'(100); bus.jojo_y = CW'(151); bus.start = 1'b1;
    c0 = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc != c0 + 3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_grounded", int'(bus.grounded), 1);
    chk("midrst_hit_floor", int'(bus.hit_floor), 1);
    chk("midrst_snap_y", int'(bus.snap_y), 400);
    reset_n = 1'b1;
    repeat (14) @(negedge clk);
    scan("after_rst_cleared", 100, 151, 0, 0, 0, 0, 151);
    wr(2, 1, 215, 64, 550);
    scan("after_rst_hit", 100, 151, 0, 1, 0, 2, 151);

    repeat (12) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
